musk_fetch_queue: RTL and testbench
===================================

// Module: musk_fetch_queue
// PURPOSE
//  Parametrised instruction fetch queue between the Muskbus line reader and the decoder.
//  - Requests aligned cache lines and holds them in a ring of NUM_LINES lines.
//  - Presents a WIN_BYTES byte window, plus its PC, at the current decode point.
//  - Supports redirect (flush to a new PC) and discards stale in-flight responses.
// PARAMETERS
//  LINE_BYTES  64  bytes per bus line; power of 2
//  NUM_LINES   4   ring depth in lines; power of 2, >=2
//  WIN_BYTES   15  decode window width; must be <= LINE_BYTES
//  ADDR_W      64  address width
// PORTS
//  clk             in   1                 clock; all state updates on posedge
//  reset           in   1                 synchronous, active-high
//  entry           in   ADDR_W            start PC; sampled while reset=1
//  redirect_valid  in   1                 flush queue and restart at redirect_addr
//  redirect_addr   in   ADDR_W            new PC (any byte alignment)
//  rd_reqcyc       out  1                 line read request to reader; level, held until rd_respcyc
//  rd_addr         out  ADDR_W            line-aligned request address; stable while rd_reqcyc=1
//  rd_respcyc      in   1                 one-cycle pulse: rd_data valid
//  rd_data         in   LINE_BYTES*8      line data, byte 0 in MSBs ([0:...] ordering)
//  win_valid       out  1                 >= WIN_BYTES contiguous bytes available
//  win_bytes       out  WIN_BYTES*8       bytes at decode point, byte 0 in MSBs
//  win_pc          out  ADDR_W            PC of win_bytes byte 0
//  consume_cnt     in   $clog2(WIN_BYTES+1)  bytes consumed this cycle; honoured only if win_valid
// BEHAVIOUR
//  State: line ring, head_line, lines_valid (0..NUM_LINES), byte_off (offset in head line),
//    fetch_addr, outstanding (0/1), drop_pending, win_pc_q.
//  Reset:
//  - rd_reqcyc=0, win_valid=0, lines_valid=0, outstanding=0, drop_pending=0.
//  - fetch_addr=entry & ~(LINE_BYTES-1); byte_off=entry[log2(LINE_BYTES)-1:0]; win_pc=entry.
//  - A reset asserted mid-operation abandons everything, including in-flight requests; the reader is reset together.
//  Fetch:
//  - At most one request is outstanding.
//  - rd_reqcyc rises the cycle after !outstanding && lines_valid < NUM_LINES is seen; outstanding is set at the same time.
//  - On rd_respcyc (not dropped): write the line at (head_line+lines_valid)%NUM_LINES, lines_valid++, fetch_addr+=LINE_BYTES, outstanding=0.
//  - A new request may start the cycle after a response (1 bubble).
//  - Full: lines_valid==NUM_LINES means no request.
//  Window:
//  - avail = lines_valid*LINE_BYTES - byte_off; win_valid = avail >= WIN_BYTES (registered-state combinational).
//  - win_bytes is extracted across the ring wrap (line NUM_LINES-1 to line 0) without a gap.
//  Consume:
//  - If win_valid: byte_off += consume_cnt and win_pc += consume_cnt.
//  - If byte_off crosses LINE_BYTES: head_line++ (mod NUM_LINES), lines_valid--, byte_off -= LINE_BYTES.
//  - consume_cnt is ignored when !win_valid. consume_cnt > WIN_BYTES is illegal (assertion).
//  - A line freed and a response written in the same cycle give a net lines_valid change of 0.
//  Redirect (highest priority; consume is ignored that cycle):
//  - lines_valid=0; byte_off=redirect_addr low bits; fetch_addr=aligned redirect_addr; win_pc=redirect_addr; win_valid=0 next cycle.
//  - If a request is outstanding and no rd_respcyc arrives this cycle: drop_pending=1, rd_reqcyc is held until that response arrives, and the response is discarded.
//  - A rd_respcyc arriving in the redirect cycle itself is discarded, with no drop_pending.
//  - A second redirect while drop_pending=1 updates the PC only; still exactly one response is dropped.
//  Latency: redirect to first win_valid = 3 cycles + reader latency, when nothing is in flight.
// CONFIGURATION
//  MUSK_FQ_PERF_EN defined:
//  - Adds ports perf_stall_cycles out 32 (counts cycles with !win_valid && !reset).
//  - Adds ports perf_lines_dropped out 32 (discarded responses).
//  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
//  MUSK_FQ_PERF_EN undefined: those ports and counters do not exist; other behaviour is identical.
// STRUCTURE
//  Package musk_fq_pkg:
//  - Constants: LINE_OFF_W=$clog2(LINE_BYTES), LINE_IDX_W=$clog2(NUM_LINES).
//  - Typedef fq_state_t: head_line, lines_valid, byte_off, outstanding, drop_pending.
//  - Function line_align(addr).
//  Sub-module musk_fq_window: combinational extractor {ring, ring[0:WIN_BYTES-1]} -> win_bytes at index head_line*LINE_BYTES+byte_off.
// TESTING
//  1. Reset with entry=0x1000, reader latency 2:
//     - rd_addr=0x1000 first, then 0x1040, 0x1080, 0x10C0.
//     - No 5th request until a consume crosses a line.
//  2. entry=0x103A (6 bytes left in line):
//     - win_valid=0 after the first line.
//     - After the 0x1040 line: win_valid=1, win_bytes = mem[0x103A..0x1048], win_pc=0x103A.
//  3. Steady consume_cnt=15 over 8 lines:
//     - win_pc advances by 15 per valid cycle.
//     - The window across the ring wrap matches the memory model byte for byte.
//  4. redirect to 0x2005 while a request to 0x10C0 is outstanding:
//     - The 0x10C0 data is dropped and never appears in the window.
//     - Next rd_addr=0x2000; first valid window has win_pc=0x2005.
//  5. redirect in the same cycle as rd_respcyc and consume_cnt=7:
//     - Response and consume are both ignored; lines_valid=0.
//  6. Reset asserted mid-stream:
//     - Next cycle: rd_reqcyc=0, win_valid=0.
//     - PERF counters (if MUSK_FQ_PERF_EN) read 0.

Source files
------------

// File: rtl/musk_fq_pkg.sv
// Shared geometry, state record and helpers for the Muskbus instruction fetch queue.
// The FQ_* constants set the default geometry and the widths of fq_state_t.
package musk_fq_pkg;

    localparam int FQ_LINE_BYTES = 64;
    localparam int FQ_NUM_LINES  = 4;
    localparam int FQ_WIN_BYTES  = 15;
    localparam int FQ_ADDR_W     = 64;

    localparam int LINE_OFF_W = $clog2(FQ_LINE_BYTES);
    localparam int LINE_IDX_W = $clog2(FQ_NUM_LINES);

    typedef struct packed {
        logic [LINE_IDX_W-1:0] head_line;
        logic [LINE_IDX_W:0]   lines_valid;
        logic [LINE_OFF_W-1:0] byte_off;
        logic                  outstanding;
        logic                  drop_pending;
    } fq_state_t;

    function automatic logic [FQ_ADDR_W-1:0] line_align(input logic [FQ_ADDR_W-1:0] addr);
        return addr & ~FQ_ADDR_W'(FQ_LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/musk_fq_window.sv
// Combinational decode-window extractor: treats the ring as one contiguous byte stream
// that wraps from the last line back to line 0, starting at head_line*LINE_BYTES+byte_off.
module musk_fq_window
    import musk_fq_pkg::*;
#(
    parameter int LINE_BYTES = FQ_LINE_BYTES,
    parameter int NUM_LINES  = FQ_NUM_LINES,
    parameter int WIN_BYTES  = FQ_WIN_BYTES
) (
    input  logic [NUM_LINES*LINE_BYTES*8-1:0] ring_flat,
    input  logic [LINE_IDX_W-1:0]             head_line,
    input  logic [LINE_OFF_W-1:0]             byte_off,
    output logic [WIN_BYTES*8-1:0]            win_bytes
);

    localparam int TOT_BYTES = NUM_LINES * LINE_BYTES;
    localparam int IDX_W     = $clog2(TOT_BYTES);

    logic [7:0]       ring_b [TOT_BYTES];
    logic [IDX_W-1:0] base_idx;

    // Power-of-two ring size: the byte index wraps naturally at IDX_W bits.
    assign base_idx = {head_line, byte_off};

    genvar gi;
    generate
        for (gi = 0; gi < TOT_BYTES; gi++) begin : g_unpack
            assign ring_b[gi] = ring_flat[(TOT_BYTES-1-gi)*8 +: 8];
        end

        for (gi = 0; gi < WIN_BYTES; gi++) begin : g_win
            logic [IDX_W-1:0] idx;
            assign idx = base_idx + IDX_W'(gi);
            assign win_bytes[(WIN_BYTES-1-gi)*8 +: 8] = ring_b[idx];
        end
    endgenerate

endmodule

// File: rtl/musk_fetch_queue.sv
// Instruction fetch queue: line ring fed by the Muskbus reader, byte window to the decoder.
// Optional MUSK_FQ_PERF_EN adds stall-cycle and dropped-response counters.
module musk_fetch_queue
    import musk_fq_pkg::*;
#(
    parameter int LINE_BYTES = FQ_LINE_BYTES,
    parameter int NUM_LINES  = FQ_NUM_LINES,
    parameter int WIN_BYTES  = FQ_WIN_BYTES,
    parameter int ADDR_W     = FQ_ADDR_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_W-1:0]              entry,
    input  logic                           redirect_valid,
    input  logic [ADDR_W-1:0]              redirect_addr,
    output logic                           rd_reqcyc,
    output logic [ADDR_W-1:0]              rd_addr,
    input  logic                           rd_respcyc,
    input  logic [LINE_BYTES*8-1:0]        rd_data,
    output logic                           win_valid,
    output logic [WIN_BYTES*8-1:0]         win_bytes,
    output logic [ADDR_W-1:0]              win_pc,
    input  logic [$clog2(WIN_BYTES+1)-1:0] consume_cnt
`ifdef MUSK_FQ_PERF_EN
    ,
    output logic [31:0]                    perf_stall_cycles,
    output logic [31:0]                    perf_lines_dropped
`endif
);

    localparam int CNT_W = $clog2(WIN_BYTES + 1);
    localparam int LV_W  = LINE_IDX_W + 1;
    localparam int AV_W  = LINE_IDX_W + 1 + LINE_OFF_W;

    fq_state_t             st_q, st_d;
    logic [ADDR_W-1:0]     fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0]     win_pc_q, win_pc_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;

    logic [LINE_BYTES*8-1:0]           ring_q [NUM_LINES];
    logic [NUM_LINES*LINE_BYTES*8-1:0] ring_flat;

    logic                  wr_en;
    logic [LINE_IDX_W-1:0] wr_idx;
    logic                  resp_drop;
    logic [AV_W-1:0]       have_bytes, need_bytes;
    logic [LINE_OFF_W:0]   off_sum;
    logic [LV_W-1:0]       lines_next;

    assign have_bytes = {st_q.lines_valid, {LINE_OFF_W{1'b0}}};
    assign need_bytes = AV_W'(st_q.byte_off) + AV_W'(WIN_BYTES);
    assign win_valid  = (have_bytes >= need_bytes);
    assign wr_idx     = st_q.head_line + st_q.lines_valid[LINE_IDX_W-1:0];

    assign rd_reqcyc  = st_q.outstanding;
    assign rd_addr    = rd_addr_q;
    assign win_pc     = win_pc_q;

    always_comb begin
        st_d         = st_q;
        fetch_addr_d = fetch_addr_q;
        win_pc_d     = win_pc_q;
        rd_addr_d    = rd_addr_q;
        wr_en        = 1'b0;
        resp_drop    = 1'b0;
        off_sum      = '0;
        lines_next   = st_q.lines_valid;

        if (redirect_valid) begin
            st_d.lines_valid = '0;
            st_d.head_line   = '0;
            st_d.byte_off    = redirect_addr[LINE_OFF_W-1:0];
            fetch_addr_d     = line_align(redirect_addr);
            win_pc_d         = redirect_addr;
            // The in-flight request keeps rd_reqcyc up until its reply, which is thrown away.
            if (st_q.outstanding) begin
                if (rd_respcyc) begin
                    st_d.outstanding  = 1'b0;
                    st_d.drop_pending = 1'b0;
                    resp_drop         = 1'b1;
                end else begin
                    st_d.drop_pending = 1'b1;
                end
            end
        end else begin
            if (st_q.outstanding) begin
                if (rd_respcyc) begin
                    st_d.outstanding = 1'b0;
                    if (st_q.drop_pending) begin
                        st_d.drop_pending = 1'b0;
                        resp_drop         = 1'b1;
                    end else begin
                        wr_en        = 1'b1;
                        lines_next   = lines_next + LV_W'(1);
                        fetch_addr_d = fetch_addr_q + ADDR_W'(LINE_BYTES);
                    end
                end
            end else if (st_q.lines_valid < LV_W'(NUM_LINES)) begin
                st_d.outstanding = 1'b1;
                rd_addr_d        = fetch_addr_q;
            end

            if (win_valid) begin
                off_sum  = {1'b0, st_q.byte_off} + (LINE_OFF_W+1)'(consume_cnt);
                win_pc_d = win_pc_q + ADDR_W'(consume_cnt);
                // consume_cnt <= WIN_BYTES <= LINE_BYTES, so at most one line is retired.
                if (off_sum[LINE_OFF_W]) begin
                    st_d.head_line = st_q.head_line + LINE_IDX_W'(1);
                    lines_next     = lines_next - LV_W'(1);
                end
                st_d.byte_off = off_sum[LINE_OFF_W-1:0];
            end
            st_d.lines_valid = lines_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q.head_line    <= '0;
            st_q.lines_valid  <= '0;
            st_q.byte_off     <= entry[LINE_OFF_W-1:0];
            st_q.outstanding  <= 1'b0;
            st_q.drop_pending <= 1'b0;
            fetch_addr_q      <= line_align(entry);
            win_pc_q          <= entry;
            rd_addr_q         <= '0;
        end else begin
            st_q         <= st_d;
            fetch_addr_q <= fetch_addr_d;
            win_pc_q     <= win_pc_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            ring_q[wr_idx] <= rd_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_flat
            assign ring_flat[(NUM_LINES-1-gi)*LINE_BYTES*8 +: LINE_BYTES*8] = ring_q[gi];
        end
    endgenerate

    musk_fq_window #(
        .LINE_BYTES (LINE_BYTES),
        .NUM_LINES  (NUM_LINES),
        .WIN_BYTES  (WIN_BYTES)
    ) u_window (
        .ring_flat  (ring_flat),
        .head_line  (st_q.head_line),
        .byte_off   (st_q.byte_off),
        .win_bytes  (win_bytes)
    );

`ifdef MUSK_FQ_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (!win_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (resp_drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign perf_stall_cycles  = stall_cnt_q;
    assign perf_lines_dropped = drop_cnt_q;
`endif

    a_consume_legal: assert property (@(posedge clk) disable iff (reset)
        win_valid |-> (consume_cnt <= CNT_W'(WIN_BYTES)));

endmodule

// File: tb/tb_musk_fetch_queue.sv
// Directed bench for musk_fetch_queue with a fixed-latency line reader and a byte-pattern memory.
module tb_musk_fetch_queue;

    logic         clk;
    logic         reset;
    logic [63:0]  entry;
    logic         redirect_valid;
    logic [63:0]  redirect_addr;
    logic         rd_reqcyc;
    logic [63:0]  rd_addr;
    logic         rd_respcyc;
    logic [511:0] rd_data;
    logic         win_valid;
    logic [119:0] win_bytes;
    logic [63:0]  win_pc;
    logic [3:0]   consume_cnt;
`ifdef MUSK_FQ_PERF_EN
    logic [31:0]  perf_stall_cycles;
    logic [31:0]  perf_lines_dropped;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] req_log [$];
    logic        req_prev = 1'b0;
    logic        rdr_busy = 1'b0;
    int          rdr_cnt  = 0;
    logic [63:0] rdr_addr = '0;

    musk_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .rd_reqcyc      (rd_reqcyc),
        .rd_addr        (rd_addr),
        .rd_respcyc     (rd_respcyc),
        .rd_data        (rd_data),
        .win_valid      (win_valid),
        .win_bytes      (win_bytes),
        .win_pc         (win_pc),
        .consume_cnt    (consume_cnt)
`ifdef MUSK_FQ_PERF_EN
        ,
        .perf_stall_cycles  (perf_stall_cycles),
        .perf_lines_dropped (perf_lines_dropped)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] mem_b(input logic [63:0] a);
        logic [7:0] m;
        m = a[15:8] * 8'd13;
        return a[7:0] ^ m ^ 8'h5A;
    endfunction

    function automatic logic [511:0] line_dat(input logic [63:0] a);
        logic [511:0] d;
        for (int b = 0; b < 64; b++) d[(63-b)*8 +: 8] = mem_b(a + 64'(b));
        return d;
    endfunction

    function automatic logic [119:0] exp_win(input logic [63:0] pc);
        logic [119:0] w;
        for (int i = 0; i < 15; i++) w[(14-i)*8 +: 8] = mem_b(pc + 64'(i));
        return w;
    endfunction

    // Line reader: accepts a level request, answers with a one-cycle pulse two cycles later.
    always @(negedge clk) begin
        rd_respcyc = 1'b0;
        if (reset) begin
            rdr_busy = 1'b0;
        end else if (rdr_busy) begin
            if (rdr_cnt == 1) begin
                rd_respcyc = 1'b1;
                rd_data    = line_dat(rdr_addr);
                rdr_busy   = 1'b0;
            end else begin
                rdr_cnt = rdr_cnt - 1;
            end
        end else if (rd_reqcyc) begin
            rdr_busy = 1'b1;
            rdr_cnt  = 2;
            rdr_addr = rd_addr;
        end
    end

    always @(negedge clk) begin
        if (rd_reqcyc && !req_prev) req_log.push_back(rd_addr);
        req_prev = rd_reqcyc;
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_resp(input string tag);
        for (int i = 0; i < 40 && !rd_respcyc; i++) step();
        chk(tag, rd_respcyc, 1'b1);
    endtask

    task automatic wait_win(input string tag);
        for (int i = 0; i < 40 && !win_valid; i++) step();
        chk(tag, win_valid, 1'b1);
    endtask

    task automatic do_reset(input logic [63:0] e);
        reset          = 1'b1;
        entry          = e;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        consume_cnt    = '0;
        step();
        step();
    endtask

    logic [63:0] exp_pc;
    logic        found;

    initial begin
        rd_respcyc = 1'b0;
        rd_data    = '0;

        // 1: reset state, first four line requests, full ring stalls fetch
        do_reset(64'h1000);
        chk("rst_reqcyc", rd_reqcyc, 1'b0);
        chk("rst_winvalid", win_valid, 1'b0);
        chk("rst_winpc", win_pc, 64'h1000);
        reset = 1'b0;
        req_log.delete();
        for (int i = 0; i < 40; i++) step();
        chk("t1_nreq", req_log.size(), 4);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            chk($sformatf("t1_addr%0d", i), req_log[i], 64'h1000 + 64'(i * 64));
        chk("t1_valid", win_valid, 1'b1);
        chk("t1_pc", win_pc, 64'h1000);
        chk("t1_win", win_bytes, exp_win(64'h1000));
        consume_cnt = 4'd15;
        for (int i = 0; i < 5; i++) step();
        consume_cnt = 4'd0;
        for (int i = 0; i < 10; i++) step();
        chk("t1_nreq5", req_log.size(), 5);
        if (req_log.size() >= 5) chk("t1_addr4", req_log[4], 64'h1100);
        chk("t1_pc75", win_pc, 64'h104B);
        chk("t1_win75", win_bytes, exp_win(64'h104B));

        // 2: entry near end of line needs a second line before the window is valid
        do_reset(64'h103A);
        reset = 1'b0;
        wait_resp("t2_resp");
        step();
        chk("t2_novalid", win_valid, 1'b0);
        wait_win("t2_valid");
        chk("t2_pc", win_pc, 64'h103A);
        chk("t2_win", win_bytes, exp_win(64'h103A));

        // 3: steady consumption of 15 bytes across eight lines and the ring wrap
        exp_pc = 64'h103A;
        consume_cnt = 4'd15;
        for (int c = 0; c < 600 && exp_pc < 64'h123A; c++) begin
            if (win_valid) begin
                chk("t3_pc", win_pc, exp_pc);
                chk("t3_win", win_bytes, exp_win(exp_pc));
                exp_pc = exp_pc + 64'd15;
            end
            step();
        end
        consume_cnt = 4'd0;
        chk("t3_done", exp_pc >= 64'h123A, 1'b1);

        // 4: redirect while the 0x10C0 request is outstanding
        do_reset(64'h1000);
        reset = 1'b0;
        req_log.delete();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (rd_reqcyc && rd_addr == 64'h10C0 && !rd_respcyc) found = 1'b1;
        end
        chk("t4_found", found, 1'b1);
        redirect_valid = 1'b1;
        redirect_addr  = 64'h2005;
        step();
        redirect_valid = 1'b0;
        chk("t4_hold_req", rd_reqcyc, 1'b1);
        chk("t4_hold_addr", rd_addr, 64'h10C0);
        chk("t4_novalid", win_valid, 1'b0);
        for (int i = 0; i < 40 && req_log.size() < 5; i++) step();
        chk("t4_nreq", req_log.size(), 5);
        if (req_log.size() >= 5) chk("t4_newaddr", req_log[4], 64'h2000);
        wait_win("t4_valid");
        chk("t4_pc", win_pc, 64'h2005);
        chk("t4_win", win_bytes, exp_win(64'h2005));
`ifdef MUSK_FQ_PERF_EN
        chk("t4_perf_drop", perf_lines_dropped, 32'd1);
`endif

        // 5: redirect coincides with a response and a consume
        wait_resp("t5_resp");
        redirect_valid = 1'b1;
        redirect_addr  = 64'h3010;
        consume_cnt    = 4'd7;
        step();
        redirect_valid = 1'b0;
        consume_cnt    = 4'd0;
        chk("t5_lines", dut.st_q.lines_valid, 0);
        chk("t5_drop_pend", dut.st_q.drop_pending, 1'b0);
        chk("t5_novalid", win_valid, 1'b0);
        chk("t5_pc", win_pc, 64'h3010);
        chk("t5_noreq", rd_reqcyc, 1'b0);
        step();
        chk("t5_req", rd_reqcyc, 1'b1);
        chk("t5_addr", rd_addr, 64'h3000);
`ifdef MUSK_FQ_PERF_EN
        chk("t5_perf_drop", perf_lines_dropped, 32'd2);
`endif

        // 6: reset in the middle of operation
        wait_win("t6_valid_pre");
        reset = 1'b1;
        entry = 64'h4000;
        step();
        chk("t6_reqcyc", rd_reqcyc, 1'b0);
        chk("t6_novalid", win_valid, 1'b0);
        chk("t6_pc", win_pc, 64'h4000);
`ifdef MUSK_FQ_PERF_EN
        chk("t6_perf_stall", perf_stall_cycles, 32'd0);
        chk("t6_perf_drop", perf_lines_dropped, 32'd0);
`endif
        reset = 1'b0;
        wait_win("t6_valid");
        chk("t6_win", win_bytes, exp_win(64'h4000));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
